// File: rtl/pri_irq_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : pri_irq_encoder
//  Purpose  : Registered priority encoder. Captures request pulses into a sticky
//             pending register and presents the winning index on a valid/ready
//             channel. Define PRI_IRQ_ENCODER_ROTATE_EN for round-robin priority.
//  Revision : 1.0 - initial release
// ============================================================================
module pri_irq_encoder #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic         out_valid,
   output logic [W-1:0] out_idx,
   input  logic         out_ready,
   output logic [N-1:0] pend,
   output logic         overflow
);

   typedef enum logic [0:0] {
      ST_EMPTY   = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

   localparam logic [W-1:0] c_IDX_TOP = W'(N - 1);
   localparam logic [N-1:0] c_ONE     = N'(1);

   state_t       r_state;
   state_t       w_state_nxt;
   logic [W-1:0] r_idx;
   logic [W-1:0] w_idx_nxt;
   logic [N-1:0] r_pend;
   logic [N-1:0] w_pend_nxt;
   logic [N-1:0] w_clr;
   logic [N-1:0] w_rem;
   logic         r_ovf;
   logic         w_ovf_nxt;
   logic         w_hs;
   logic [W-1:0] w_sel_pend;
   logic [W-1:0] w_sel_rem;

   function automatic logic [W-1:0] f_highest(input logic [N-1:0] v);
      f_highest = '0;
      for (int i = 0; i < N; i++) begin
         if (v[i]) f_highest = i[W-1:0];
      end
   endfunction

`ifdef PRI_IRQ_ENCODER_ROTATE_EN
   logic [W-1:0] r_ptr;
   logic [W-1:0] w_ptr_nxt;

   // Searching down from p with wrap: prefer bits at or below p, else the top.
   function automatic logic [W-1:0] f_select(input logic [N-1:0] v,
                                             input logic [W-1:0] p);
      logic [N-1:0] lo;
      for (int i = 0; i < N; i++) begin
         lo[i] = v[i] && (i[W-1:0] <= p);
      end
      f_select = (lo != '0) ? f_highest(lo) : f_highest(v);
   endfunction

   assign w_ptr_nxt  = w_hs ? ((r_idx == '0) ? c_IDX_TOP : r_idx - 1'b1) : r_ptr;
   assign w_sel_pend = f_select(r_pend, r_ptr);
   assign w_sel_rem  = f_select(w_rem, w_ptr_nxt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ptr <= c_IDX_TOP;
      else        r_ptr <= w_ptr_nxt;
   end
`else
   assign w_sel_pend = f_highest(r_pend);
   assign w_sel_rem  = f_highest(w_rem);
`endif

   assign w_hs       = (r_state == ST_PRESENT) && out_ready;
   assign w_clr      = w_hs ? (c_ONE << r_idx) : '0;
   assign w_rem      = r_pend & ~w_clr;
   assign w_pend_nxt = w_rem | req;
   assign w_ovf_nxt  = |(req & w_rem);

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         ST_EMPTY: begin
            if (r_pend != '0) begin
               w_state_nxt = ST_PRESENT;
               w_idx_nxt   = w_sel_pend;
            end
         end
         ST_PRESENT: begin
            // Requests landing on this edge are not in w_rem; seen next edge.
            if (w_hs) begin
               if (w_rem != '0) begin
                  w_idx_nxt = w_sel_rem;
               end else begin
                  w_state_nxt = ST_EMPTY;
                  w_idx_nxt   = '0;
               end
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
            w_idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         r_idx   <= '0;
         r_pend  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_pend  <= w_pend_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   assign out_valid = (r_state == ST_PRESENT);
   assign out_idx   = r_idx;
   assign pend      = r_pend;
   assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pri_irq_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pri_irq_encoder
//  Purpose  : Self-checking bench for pri_irq_encoder (N=8), directed scenarios
//             plus random traffic against an event-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pri_irq_encoder;

   localparam int N = 8;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req = '0;
   logic         out_ready = 1'b0;
   logic         out_valid;
   logic [W-1:0] out_idx;
   logic [N-1:0] pend;
   logic         overflow;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [N-1:0] m_pend;
   bit           m_valid;
   int           m_idx;
   int           m_ptr;
   bit           m_ovf;

   always #5 clk = ~clk;

   pri_irq_encoder #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .out_valid (out_valid),
      .out_idx   (out_idx),
      .out_ready (out_ready),
      .pend      (pend),
      .overflow  (overflow)
   );

   function automatic int pick(input logic [N-1:0] v, input int p);
`ifdef PRI_IRQ_ENCODER_ROTATE_EN
      for (int k = 0; k < N; k++) begin
         int j;
         j = (p - k + N) % N;
         if (v[j]) return j;
      end
`else
      for (int j = N - 1; j >= 0; j--) begin
         if (v[j]) return j;
      end
`endif
      return 0;
   endfunction

   task automatic model_reset();
      m_pend  = '0;
      m_valid = 0;
      m_idx   = 0;
      m_ptr   = N - 1;
      m_ovf   = 0;
   endtask

   // Drive one cycle of inputs, advance the model, and settle past the edge.
   task automatic tick(input logic [N-1:0] r, input logic rd);
      logic [N-1:0] rem;
      bit           nv;
      int           ni;
      int           np;
      bit           hs;
      req       = r;
      out_ready = rd;
      hs  = m_valid && rd;
      rem = m_pend;
      if (hs) rem[m_idx] = 1'b0;
      nv = m_valid;
      ni = m_idx;
      np = m_ptr;
      if (!m_valid) begin
         if (m_pend != 0) begin
            nv = 1;
            ni = pick(m_pend, m_ptr);
         end
      end else if (hs) begin
         np = (m_idx == 0) ? N - 1 : m_idx - 1;
         if (rem != 0) ni = pick(rem, np);
         else begin
            nv = 0;
            ni = 0;
         end
      end
      @(posedge clk);
      m_ovf   = ((r & rem) != 0);
      m_pend  = rem | r;
      m_valid = nv;
      m_idx   = ni;
      m_ptr   = np;
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      req = '0;
      out_ready = 1'b0;
      model_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (out_valid !== 1'b0 || out_idx !== '0 || pend !== '0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: valid=%b idx=%0d pend=%h ovf=%b, required all 0",
                  out_valid, out_idx, pend, overflow);
      end
   endtask

   task automatic test_fixed_priority();
      do_reset();
      tick(8'h81, 1'b1);
      checks++;
      if (pend !== 8'h81 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL capture: pend=%h valid=%b, required pend=81 valid=0", pend, out_valid);
      end
      tick(8'h00, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 3'd7) begin
         errors++;
         $display("FAIL first_grant: valid=%b idx=%0d, required valid=1 idx=7", out_valid, out_idx);
      end
      tick(8'h00, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 3'd0 || pend !== 8'h01) begin
         errors++;
         $display("FAIL back_to_back: valid=%b idx=%0d pend=%h, required 1/0/01",
                  out_valid, out_idx, pend);
      end
      tick(8'h00, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || out_idx !== 3'd0 || pend !== 8'h00) begin
         errors++;
         $display("FAIL drain: valid=%b idx=%0d pend=%h, required 0/0/00", out_valid, out_idx, pend);
      end
   endtask

   task automatic test_hold();
      do_reset();
      tick(8'h04, 1'b0);
      tick(8'h00, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 3'd2) begin
         errors++;
         $display("FAIL hold_present: valid=%b idx=%0d, required 1/2", out_valid, out_idx);
      end
      tick(8'h80, 1'b0);
      tick(8'h00, 1'b0);
      checks++;
      if (out_idx !== 3'd2 || pend !== 8'h84 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL hold_stable: idx=%0d pend=%h valid=%b, required 2/84/1", out_idx, pend, out_valid);
      end
      tick(8'h00, 1'b1);
      checks++;
      if (out_idx !== 3'd7 || pend !== 8'h80 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL hold_release: idx=%0d pend=%h valid=%b, required 7/80/1", out_idx, pend, out_valid);
      end
      tick(8'h00, 1'b1);
   endtask

   task automatic test_overflow();
      do_reset();
      tick(8'h08, 1'b0);
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_first: overflow=%b, required 0", overflow);
      end
      tick(8'h08, 1'b0);
      checks++;
      if (overflow !== 1'b1 || pend !== 8'h08) begin
         errors++;
         $display("FAIL ovf_second: overflow=%b pend=%h, required 1/08", overflow, pend);
      end
      tick(8'h00, 1'b0);
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_pulse_width: overflow=%b, required 0", overflow);
      end
      tick(8'h08, 1'b1);
      checks++;
      if (overflow !== 1'b0 || pend[3] !== 1'b1) begin
         errors++;
         $display("FAIL collision: overflow=%b pend=%h, required ovf=0 pend[3]=1", overflow, pend);
      end
      tick(8'h00, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 3'd3) begin
         errors++;
         $display("FAIL collision_regrant: valid=%b idx=%0d, required 1/3", out_valid, out_idx);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      tick(8'hFF, 1'b0);
      tick(8'h00, 1'b0);
      checks++;
      if (pend !== 8'hFF || out_valid !== 1'b1 || out_idx !== 3'd7) begin
         errors++;
         $display("FAIL pre_reset: pend=%h valid=%b idx=%0d, required FF/1/7", pend, out_valid, out_idx);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_idx !== '0 || pend !== '0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: valid=%b idx=%0d pend=%h ovf=%b, required all 0",
                  out_valid, out_idx, pend, overflow);
      end
      model_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      tick(8'h00, 1'b1);
      tick(8'h00, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || pend !== '0) begin
         errors++;
         $display("FAIL post_reset_idle: valid=%b pend=%h, required 0/00", out_valid, pend);
      end
      tick(8'h02, 1'b0);
      tick(8'h00, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 3'd1) begin
         errors++;
         $display("FAIL post_reset_grant: valid=%b idx=%0d, required 1/1", out_valid, out_idx);
      end
   endtask

   task automatic test_rotation();
      int got [6];
      do_reset();
      tick(8'hA2, 1'b1);
      tick(8'h00, 1'b1);
      for (int g = 0; g < 6; g++) begin
         got[g] = out_valid ? int'(out_idx) : -1;
         checks++;
         if (out_valid !== m_valid || int'(out_idx) != m_idx) begin
            errors++;
            $display("FAIL rotation_model[%0d]: valid=%b idx=%0d, required %0d/%0d",
                     g, out_valid, out_idx, m_valid, m_idx);
         end
         tick(out_valid ? (8'h01 << out_idx) : 8'h00, 1'b1);
      end
`ifdef PRI_IRQ_ENCODER_ROTATE_EN
      checks++;
      if (got[0] != 7 || got[1] != 5 || got[2] != 1 || got[3] != 7 || got[4] != 5 || got[5] != 1) begin
         errors++;
         $display("FAIL rotation_order: got %0d %0d %0d %0d %0d %0d, required 7 5 1 7 5 1",
                  got[0], got[1], got[2], got[3], got[4], got[5]);
      end
`endif
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         r = '0;
         for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 4) == 0);
         tick(r, 1'($urandom_range(0, 2) != 0));
         checks++;
         if (pend !== m_pend || out_valid !== m_valid || overflow !== m_ovf ||
             int'(out_idx) != m_idx) begin
            errors++;
            $display("FAIL random[%0d]: pend=%h valid=%b idx=%0d ovf=%b, required %h/%0d/%0d/%0d",
                     c, pend, out_valid, out_idx, overflow, m_pend, m_valid, m_idx, m_ovf);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fixed_priority();
      test_hold();
      test_overflow();
      test_reset_mid();
      test_rotation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pri_irq_encoder.md
# pri_irq_encoder

Parametrised, registered priority encoder for N event lines. Incoming request pulses are captured into a sticky pending register. The highest-priority pending index is presented on a valid/ready output channel, and its pending bit is cleared when the consumer accepts it. It is the clocked successor of the 8-to-3 combinational priority encoder and feeds interrupt/event indices to a downstream controller.

## Interface
- `N`, 8, number of request lines; 2..256.
- `W`, `$clog2(N)`, width of the encoded index; derived, do not override.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req` input N: event pulses; each bit sampled high on a `clk` edge counts as one event.
- `out_valid` output 1: `out_idx` holds a pending event.
- `out_idx` output W: encoded index of the presented event.
- `out_ready` input 1: consumer accepts the presented event.
- `pend` output N: pending register, for status.
- `overflow` output 1: one-cycle pulse; an event was lost on a bit that was already pending.

## Operation
- Pending capture, each edge: `pend_next = (pend & ~clr) | req`.
  - `clr` is the one-hot of `out_idx` when `out_valid && out_ready`, otherwise 0.
- Selection uses fixed priority: the highest set index wins (bit N-1 is highest), matching the MSB-first rule of the 8-to-3 encoder.
- Output register (`out_valid`, `out_idx`) has two states: EMPTY (`out_valid`=0) and PRESENT (`out_valid`=1).
  - EMPTY: if `pend` != 0, load `out_idx` = select(`pend`) and go to PRESENT. Otherwise stay.
  - PRESENT with `!out_ready`: hold `out_idx` unchanged, even if a higher-priority request arrives.
  - PRESENT with `out_ready` (handshake): clear that pending bit. Evaluate `rem = pend & ~clr`.
    - If `rem` != 0, load select(`rem`) and stay in PRESENT. This gives back-to-back grants.
    - Otherwise go to EMPTY.
  - Requests arriving on the handshake edge are not in `rem`. They are considered from the next edge on.
- Overflow: `overflow` is registered high for one cycle when `req[i]` && `pend[i]` && !`clr[i]` for any `i`.
- Same-bit collision: when `req[i]` arrives on the edge that accepts `i`, `pend[i]` stays set. The new event is retained, and `overflow` is not raised.
- A `req` bit held high for K edges counts as K events. Every repeat after the first raises `overflow` while the bit is pending.
- `out_idx` is don't-care when `out_valid`=0, but it is driven to 0.

## Timing
- Reset, asynchronous assert: `pend`=0, `out_valid`=0, `out_idx`=0, `overflow`=0, rotation pointer=N-1.
  - All outputs change immediately on reset assertion, including mid-handshake. Pending events are discarded.
  - Reset release is synchronous to `clk`. The first `req` capture happens on the first edge after release.
- Latency, idle block:
  - `req[i]` sampled at edge k sets `pend[i]` after edge k.
  - `out_valid`=1 and `out_idx`=i after edge k+1.
- Throughput: one accepted event per cycle while `pend` is non-empty.
- Handshake: transfer happens on an edge with `out_valid && out_ready`.
  - `out_ready` may be high while `out_valid`=0; it has no effect then.
  - `out_valid` never drops without a handshake, except on reset.

## Configuration
- Macro: `PRI_IRQ_ENCODER_ROTATE_EN`.
- Without it: fixed priority as in Operation, and there is no pointer register.
- With it: round-robin priority through a W-bit pointer `ptr`, reset to N-1.
  - Selection searches downward from `ptr`, wrapping from 0 to N-1. The first set bit wins.
  - On each handshake: `ptr` = (`out_idx`==0) ? N-1 : `out_idx`-1.
  - The `rem` selection on a handshake edge uses the updated pointer value.
  - Port list is identical in both builds.

## Test plan
All scenarios use N=8.
- **Fixed priority:** `req`=8'b1000_0001 for one edge, `out_ready`=1.
  - Required: `out_idx`=7 presented, then 0 on consecutive cycles, then `out_valid`=0, `pend`=0.
  - Both events accepted in 2 consecutive handshakes.
- **Hold stability:** `req`=8'h04 with `out_ready`=0; once `out_idx`=2 is presented, pulse `req`=8'h80.
  - Required: `out_idx` stays 2 until `out_ready`=1, then 7 on the next cycle.
  - `pend` shows 8'h84, then 8'h80.
- **Overflow and collision:**
  - Pulse `req[3]` twice with `out_ready`=0. Required: `overflow`=1 for exactly one cycle after the second edge, and `pend`=8'h08.
  - Then set `out_ready`=1 and drive `req[3]` on the accept edge. Required: no overflow, `pend[3]` stays 1, `out_idx`=3 presented again.
- **Reset mid-operation:** `pend`=8'hFF with `out_valid`=1; assert `rst_n`=0 between edges.
  - Required: `out_valid`, `out_idx`, `pend`, `overflow` all 0 immediately.
  - After release: no output until a new `req` arrives.
- **Rotation (`PRI_IRQ_ENCODER_ROTATE_EN` defined):** `req[7]`, `req[5]`, `req[1]` re-pulsed after every accept, `out_ready`=1.
  - Required grant order: 7, 5, 1, 7, 5, 1.
  - Without the macro, the same stimulus must give 7 repeatedly.
